// File: rtl/bcd_timer_pkg.sv
// Shared types, constants and BCD helpers for the cascaded BCD timer.
package bcd_timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Value a digit takes after one edge with the given carry-in.
    function automatic logic [3:0] bcd_next(input logic [3:0] q, input logic cin);
        if (!cin) begin
            return q;
        end
        return (q == BCD_MAX) ? BCD_ZERO : q + 4'd1;
    endfunction

    // Clamp a raw nibble into the BCD range.
    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain; Cout is combinational so a full ripple settles in one cycle.
// Load inputs exist only when BCD_TIMER_LOAD_EN is defined.
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Clr,
`ifdef BCD_TIMER_LOAD_EN
    input  logic       Ld,
    input  logic [3:0] Ld_val,
`endif
    input  logic       Cin,
    output logic       Cout,
    output logic [3:0] q
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (Clr) begin
            q_d = BCD_ZERO;
        end
`ifdef BCD_TIMER_LOAD_EN
        else if (Ld) begin
            q_d = bcd_sat(Ld_val);
        end
`endif
        else begin
            q_d = bcd_next(q_q, Cin);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign Cout = Cin & (q_q == BCD_MAX);
    assign q    = q_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run/pause/clear sequencer, prescaler and target comparator for a chain of bcd_digit.
// Optional Load/Load_val parallel preset is built when BCD_TIMER_LOAD_EN is defined.
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PW       = 16
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic                        Stop,
    input  logic                        Clear,
    input  logic                        Mode,
    input  logic [DIGIT_W*DIGITS-1:0]   Target,
`ifdef BCD_TIMER_LOAD_EN
    input  logic                        Load,
    input  logic [DIGIT_W*DIGITS-1:0]   Load_val,
`endif
    output logic [DIGIT_W*DIGITS-1:0]   Count,
    output logic                        Running,
    output logic                        Done,
    output logic                        Wrap
);

    localparam int unsigned CW = DIGIT_W * DIGITS;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            wrap_q, wrap_d;

    logic            tick_c;
    logic            clr_c;
    logic            ld_c;
    logic [CW-1:0]   inc_c;
    logic            carry_c;
    logic            all9_c;

    // Count as it would read after a tick; feeds the target compare and wrap detect.
    always_comb begin
        inc_c   = Count;
        carry_c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            inc_c[DIGIT_W*i +: DIGIT_W] = bcd_next(Count[DIGIT_W*i +: DIGIT_W], carry_c);
            carry_c = carry_c & (Count[DIGIT_W*i +: DIGIT_W] == BCD_MAX);
        end
        all9_c = carry_c;
    end

    // Command decode: Clear > Load > Stop > Start, then RUN-time prescaling.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        tick_c  = 1'b0;
        clr_c   = 1'b0;
        ld_c    = 1'b0;
        if (Clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            clr_c   = 1'b1;
        end
`ifdef BCD_TIMER_LOAD_EN
        else if (Load && (state_q != ST_RUN)) begin
            ld_c    = 1'b1;
            presc_d = '0;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end
`endif
        else if (Stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (Start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (Start) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                        clr_c   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (presc_q == PW'(PRESCALE - 1)) begin
                        presc_d = '0;
                        tick_c  = 1'b1;
                        wrap_d  = all9_c;
                        if (Mode && (inc_c == Target)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    // Digit chain: each digit's carry-in is the previous digit's carry-out.
    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_dig
        logic       cin_w;
        logic       cout_w;
        logic [3:0] q_w;

        if (i == 0) begin : g_lsd
            assign cin_w = tick_c;
        end else begin : g_msd
            assign cin_w = g_dig[i-1].cout_w;
        end

        bcd_digit u_digit (
            .Clk    (Clk),
            .Rst    (Rst),
            .Clr    (clr_c),
`ifdef BCD_TIMER_LOAD_EN
            .Ld     (ld_c),
            .Ld_val (Load_val[DIGIT_W*i +: DIGIT_W]),
`endif
            .Cin    (cin_w),
            .Cout   (cout_w),
            .q      (q_w)
        );

        assign Count[DIGIT_W*i +: DIGIT_W] = q_w;
    end

`ifndef BCD_TIMER_LOAD_EN
    logic unused_ld_c;
    assign unused_ld_c = ld_c;
`endif

    assign Running = running_q;
    assign Done    = done_q;
    assign Wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Scoreboard bench for bcd_timer_ctrl (DIGITS=2, PRESCALE=4): every visible output change is an event
// checked against a queue of expected (cycle, Count, Running, Done, Wrap) tuples.
module tb_bcd_timer_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic       Stop;
    logic       Clear;
    logic       Mode;
    logic [7:0] Target;
    logic [7:0] Count;
    logic       Running;
    logic       Done;
    logic       Wrap;
`ifdef BCD_TIMER_LOAD_EN
    logic       Load;
    logic [7:0] Load_val;
`endif

    bcd_timer_ctrl #(
        .DIGITS   (2),
        .PRESCALE (4),
        .PW       (3)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Stop     (Stop),
        .Clear    (Clear),
        .Mode     (Mode),
        .Target   (Target),
`ifdef BCD_TIMER_LOAD_EN
        .Load     (Load),
        .Load_val (Load_val),
`endif
        .Count    (Count),
        .Running  (Running),
        .Done     (Done),
        .Wrap     (Wrap)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       run;
        logic       done;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic void push(input int c, input logic [7:0] v, input logic r,
                                 input logic d, input logic w);
        exp_t e;
        e.cyc  = c;
        e.cnt  = v;
        e.run  = r;
        e.done = d;
        e.wrap = w;
        exp_q.push_back(e);
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    task automatic pulse(input logic st, input logic sp, input logic cl, input logic rs);
        Start = st;
        Stop  = sp;
        Clear = cl;
        Rst   = rs;
        @(negedge Clk);
        Start = 1'b0;
        Stop  = 1'b0;
        Clear = 1'b0;
        Rst   = 1'b0;
    endtask

    // Monitor: any change of the observable tuple is one event to score.
    initial begin
        logic [10:0] prev;
        logic [10:0] cur;
        bit          first;
        exp_t        e;
        prev  = '0;
        first = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            if (mon_en) begin
                cur = {Count, Running, Done, Wrap};
                if (first || (cur !== prev)) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: cyc=%0d cnt=%h run=%b done=%b wrap=%b, none required",
                                 cyc, Count, Running, Done, Wrap);
                    end else begin
                        e = exp_q.pop_front();
                        if ((e.cyc != cyc) || (e.cnt !== Count) || (e.run !== Running) ||
                            (e.done !== Done) || (e.wrap !== Wrap)) begin
                            n_fail++;
                            $display("FAIL event: got cyc=%0d cnt=%h run=%b done=%b wrap=%b, required cyc=%0d cnt=%h run=%b done=%b wrap=%b",
                                     cyc, Count, Running, Done, Wrap, e.cyc, e.cnt, e.run, e.done, e.wrap);
                        end
                    end
                end
                prev  = cur;
                first = 1'b0;
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached, %0d events still pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, k3, k4, k5;
`ifdef BCD_TIMER_LOAD_EN
        int k6;
`endif
        Rst    = 1'b1;
        Start  = 1'b0;
        Stop   = 1'b0;
        Clear  = 1'b0;
        Mode   = 1'b0;
        Target = 8'h00;
`ifdef BCD_TIMER_LOAD_EN
        Load     = 1'b0;
        Load_val = 8'h00;
`endif
        // Reset state
        wait_cyc(2);
        mon_en = 1'b1;
        push(3, 8'h00, 0, 0, 0);
        wait_cyc(3);
        Rst = 1'b0;

        // Free run 00 -> 99 -> 00 with Wrap pulse
        wait_cyc(4);
        k = 5;
        push(k, 8'h00, 1, 0, 0);
        for (int n = 1; n < 100; n++) push(k + 4 * n, bcd2(n), 1, 0, 0);
        push(k + 400, 8'h00, 1, 0, 1);
        push(k + 401, 8'h00, 1, 0, 0);
        pulse(1, 0, 0, 0);

        // Stop with prescaler at 2, resume after 10 cycles: increment 2 cycles after resume
        wait_cyc(k + 402);
        push(k + 403, 8'h00, 0, 0, 0);
        pulse(0, 1, 0, 0);
        wait_cyc(k + 413);
        push(k + 414, 8'h00, 1, 0, 0);
        push(k + 416, 8'h01, 1, 0, 0);
        pulse(1, 0, 0, 0);

        // Start+Stop in RUN pauses; Clear+Stop+Start goes IDLE at 00
        wait_cyc(k + 417);
        push(k + 418, 8'h01, 0, 0, 0);
        pulse(1, 1, 0, 0);
        wait_cyc(k + 420);
        push(k + 421, 8'h00, 0, 0, 0);
        pulse(1, 1, 1, 0);

        // Mode=1, Target=25: Done pulse, hold 20 cycles, restart from 00
        wait_cyc(k + 422);
        Mode   = 1'b1;
        Target = 8'h25;
        k2 = k + 423;
        push(k2, 8'h00, 1, 0, 0);
        for (int n = 1; n < 25; n++) push(k2 + 4 * n, bcd2(n), 1, 0, 0);
        push(k2 + 100, 8'h25, 0, 1, 0);
        push(k2 + 101, 8'h25, 0, 0, 0);
        pulse(1, 0, 0, 0);
        wait_cyc(k2 + 121);
        Mode = 1'b0;
        k3 = k2 + 122;
        push(k3, 8'h00, 1, 0, 0);
        for (int n = 1; n <= 37; n++) push(k3 + 4 * n, bcd2(n), 1, 0, 0);
        pulse(1, 0, 0, 0);

        // Rst mid-run at 37
        wait_cyc(k3 + 149);
        push(k3 + 150, 8'h00, 0, 0, 0);
        pulse(0, 0, 0, 1);

        // Mode=1, Target=00: matches only through wrap, Done and Wrap together
        wait_cyc(k3 + 152);
        Mode   = 1'b1;
        Target = 8'h00;
        k4 = k3 + 153;
        push(k4, 8'h00, 1, 0, 0);
        for (int n = 1; n < 100; n++) push(k4 + 4 * n, bcd2(n), 1, 0, 0);
        push(k4 + 400, 8'h00, 0, 1, 1);
        push(k4 + 401, 8'h00, 0, 0, 0);
        pulse(1, 0, 0, 0);

        // Non-BCD target never matches; restart from DONE then Clear
        wait_cyc(k4 + 405);
        Target = 8'h1A;
        k5 = k4 + 406;
        push(k5, 8'h00, 1, 0, 0);
        for (int n = 1; n <= 12; n++) push(k5 + 4 * n, bcd2(n), 1, 0, 0);
        pulse(1, 0, 0, 0);
        wait_cyc(k5 + 49);
        push(k5 + 50, 8'h00, 0, 0, 0);
        pulse(0, 0, 1, 0);

`ifdef BCD_TIMER_LOAD_EN
        // Load 9C in PAUSE saturates to 99 and zeroes prescaler; Load in RUN ignored
        wait_cyc(k5 + 52);
        k6 = k5 + 53;
        push(k6, 8'h00, 1, 0, 0);
        push(k6 + 4, 8'h01, 1, 0, 0);
        pulse(1, 0, 0, 0);
        wait_cyc(k6 + 5);
        push(k6 + 6, 8'h01, 0, 0, 0);
        pulse(0, 1, 0, 0);
        wait_cyc(k6 + 7);
        Load_val = 8'h9C;
        Load     = 1'b1;
        push(k6 + 8, 8'h99, 0, 0, 0);
        @(negedge Clk);
        Load = 1'b0;
        wait_cyc(k6 + 9);
        push(k6 + 10, 8'h99, 1, 0, 0);
        push(k6 + 14, 8'h00, 1, 0, 1);
        push(k6 + 15, 8'h00, 1, 0, 0);
        pulse(1, 0, 0, 0);
        Load_val = 8'h42;
        Load     = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        wait_cyc(k6 + 15);
        push(k6 + 16, 8'h00, 0, 0, 0);
        pulse(0, 0, 1, 0);
`endif

        // Quiet tail, then every required event must have been seen
        repeat (20) @(negedge Clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d unseen, required 0 (next cyc=%0d cnt=%h)",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
